regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order WB stage and
//  long-latency units (M-ext mul/div, F-ext), which return results out of band.
//  Sits between the WB-stage outputs and the regfile write port.
//  Buffers unit results in a small FIFO; the pipe has priority.
//  An anti-starvation counter stalls the pipe to drain the FIFO.
//  Exports a pending-rd mask to the hazard unit.
// PARAMETERS
//  XLEN          32  data width
//  RF_ADDR_W     5   register index width
//  DEPTH         2   unit-result FIFO entries (>=1)
//  STARVE_LIMIT  3   cycles FIFO head may wait before pipe is force-stalled (>=1)
// PORTS
//  clk          in   1          clock
//  rst          in   1          synchronous reset, active-high
//  pipe_wr_en   in   1          WB stage wants to write
//  pipe_rd      in   RF_ADDR_W  WB destination
//  pipe_data    in   XLEN       WB data
//  lu_valid     in   1          unit result valid
//  lu_rd        in   RF_ADDR_W  unit destination
//  lu_data      in   XLEN       unit data
//  lu_ready     out  1          FIFO accepts result; push = lu_valid & lu_ready
//  pipe_stall   out  1          pipe must hold WB inputs this cycle
//  rf_wr_en     out  1          regfile write enable (registered)
//  rf_rd        out  RF_ADDR_W  regfile write index (registered)
//  rf_data      out  XLEN       regfile write data (registered)
//  pending_mask out  2**RF_ADDR_W  one-hot OR of rd values not yet written by unit results
// BEHAVIOUR
//  Reset (rst high at clk edge):
//   - FIFO emptied; starve_cnt=0; rf_wr_en=0, rf_rd=0, rf_data=0; pending_mask=0.
//   - lu_ready=0 while rst high; buffered results discarded (mid-op reset drops them).
//  lu_ready = !rst & (count<DEPTH); no full-bypass; push when full is impossible.
//  Push with lu_rd==0: handshake completes, entry dropped (x0 never written).
//  force = !empty & (starve_cnt==STARVE_LIMIT); pipe_stall = force.
//   - Depends on state only, not on pipe_wr_en.
//  pipe_req = pipe_wr_en & (pipe_rd!=0) & !force; pipe writes to x0 are discarded.
//  Grant each cycle, in priority order:
//   - pipe_req -> pipe.
//   - else if !empty -> pop FIFO head.
//   - else none.
//  Output stage: next-cycle rf_* = granted write; rf_wr_en=0 when no grant.
//   - rf_rd/rf_data keep their old values when no grant.
//   - Latency is 1 cycle from grant to rf_wr_en.
//  starve_cnt:
//   - 0 when empty or on pop.
//   - +1 when !empty and no pop.
//   - Saturates at STARVE_LIMIT (force guarantees a pop that cycle).
//  Push and pop in the same cycle: count unchanged, FIFO order preserved.
//   - A pushed entry is never popped in its push cycle.
//  pending_mask: bit r set for every valid FIFO entry with rd==r.
//   - Also set for rf_rd when the output stage holds a unit write.
//   - Combinational from registers.
//  WAW ordering is not checked here: the hazard unit stalls any issuing instr whose rd
//   is set in pending_mask. Bench asserts pipe grant never targets a pending rd.
//  pipe_stall high while pipe_wr_en high: pipe inputs must be held stable next cycle.
// TESTING
//  1. Reset: rst=1 for 2 cycles -> rf_wr_en=0, lu_ready=0, pending_mask=0.
//     Then rst=0 -> lu_ready=1.
//  2. Pipe only: pipe_wr_en=1, rd=5, data=0xDEADBEEF
//     -> next cycle rf_wr_en=1, rf_rd=5, rf_data=0xDEADBEEF; pipe rd=0 -> no write.
//  3. Idle pipe: push lu rd=7, data=0x1234
//     -> pending_mask[7]=1 next cycle; popped the cycle after.
//     -> rf write (7,0x1234) 2 cycles after push; mask clears after that write.
//  4. Full: DEPTH=2, pipe writes every cycle, push rd=3 then rd=4 -> lu_ready=0.
//     -> after 3 waiting cycles pipe_stall=1 for 1 cycle, rd=3 written.
//     -> again for rd=4; order 3 then 4.
//  5. Simultaneous push/pop with count=1 -> count stays 1, FIFO order preserved.
//     lu push rd=0 -> accepted, never written.
//  6. Reset with 2 entries buffered and starve_cnt=2
//     -> all dropped, no rf write after reset, mask=0.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Shares the single register-file write port between the in-order WB stage
//   and long-latency units (mul/div, FP) that return results out of band.
//   Unit results are buffered in a small FIFO. The pipe has priority, but a
//   starvation counter force-stalls the pipe once the FIFO head has waited
//   STARVE_LIMIT cycles, so the head is guaranteed to drain.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   pipe_wr_en/pipe_rd/pipe_data    WB-stage write request
//   lu_valid/lu_rd/lu_data          unit result, accepted when lu_ready
//   lu_ready                        FIFO has room (low during reset)
//   pipe_stall                      WB must hold its inputs this cycle
//   rf_wr_en/rf_rd/rf_data          registered regfile write port
//   pending_mask                    one-hot OR of unit rds not yet written
module regfile_wr_arbiter #(
    parameter int XLEN         = 32,
    parameter int RF_ADDR_W    = 5,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pipe_wr_en,
    input  logic [RF_ADDR_W-1:0]      pipe_rd,
    input  logic [XLEN-1:0]           pipe_data,
    input  logic                      lu_valid,
    input  logic [RF_ADDR_W-1:0]      lu_rd,
    input  logic [XLEN-1:0]           lu_data,
    output logic                      lu_ready,
    output logic                      pipe_stall,
    output logic                      rf_wr_en,
    output logic [RF_ADDR_W-1:0]      rf_rd,
    output logic [XLEN-1:0]           rf_data,
    output logic [(2**RF_ADDR_W)-1:0] pending_mask
);
    localparam int NREG  = 2 ** RF_ADDR_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    // FIFO storage; valid bits are kept per slot so the pending mask can be
    // built without decoding pointer distances.
    logic [RF_ADDR_W-1:0] fifo_rd_mem   [DEPTH];
    logic [XLEN-1:0]      fifo_data_mem [DEPTH];
    logic [DEPTH-1:0]     valid_reg;
    logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg, count_next;
    logic [STV_W-1:0]     starve_cnt_reg, starve_cnt_next;

    logic                 rf_wr_en_reg;
    logic [RF_ADDR_W-1:0] rf_rd_reg;
    logic [XLEN-1:0]      rf_data_reg;
    logic                 out_unit_reg;   // output stage holds a unit result

    logic empty, full, push, push_store, force_drain, pipe_req, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty       = (count_reg == '0);
    assign full        = (count_reg == CNT_W'(DEPTH));
    assign lu_ready    = !rst && !full;
    assign push        = lu_valid && lu_ready;
    // x0 results complete the handshake but are never stored.
    assign push_store  = push && (lu_rd != '0);
    // Depends only on state so the stall never combinationally loops through WB.
    assign force_drain = !empty && (starve_cnt_reg == STV_W'(STARVE_LIMIT));
    assign pipe_stall  = force_drain;
    assign pipe_req    = pipe_wr_en && (pipe_rd != '0) && !force_drain;
    // Pop reads the registered head, so an entry pushed this cycle is never popped.
    assign pop         = !pipe_req && !empty;

    always_comb begin
        count_next = count_reg;
        case ({push_store, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (empty || pop)
            starve_cnt_next = '0;
        else if (starve_cnt_reg != STV_W'(STARVE_LIMIT))
            starve_cnt_next = starve_cnt_reg + STV_W'(1);
    end

    // Storage array has no reset; validity is tracked by valid_reg.
    always_ff @(posedge clk) begin
        if (push_store) begin
            fifo_rd_mem[wr_ptr_reg]   <= lu_rd;
            fifo_data_mem[wr_ptr_reg] <= lu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg      <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            starve_cnt_reg <= '0;
            rf_wr_en_reg   <= 1'b0;
            rf_rd_reg      <= '0;
            rf_data_reg    <= '0;
            out_unit_reg   <= 1'b0;
        end else begin
            count_reg      <= count_next;
            starve_cnt_reg <= starve_cnt_next;
            for (int i = 0; i < DEPTH; i++) begin
                if (pop && (rd_ptr_reg == PTR_W'(i)))
                    valid_reg[i] <= 1'b0;
                else if (push_store && (wr_ptr_reg == PTR_W'(i)))
                    valid_reg[i] <= 1'b1;
            end
            if (push_store)
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);

            if (pipe_req) begin
                rf_wr_en_reg <= 1'b1;
                rf_rd_reg    <= pipe_rd;
                rf_data_reg  <= pipe_data;
                out_unit_reg <= 1'b0;
            end else if (pop) begin
                rf_wr_en_reg <= 1'b1;
                rf_rd_reg    <= fifo_rd_mem[rd_ptr_reg];
                rf_data_reg  <= fifo_data_mem[rd_ptr_reg];
                out_unit_reg <= 1'b1;
            end else begin
                rf_wr_en_reg <= 1'b0;
                out_unit_reg <= 1'b0;
            end
        end
    end

    assign rf_wr_en = rf_wr_en_reg;
    assign rf_rd    = rf_rd_reg;
    assign rf_data  = rf_data_reg;

    // A unit rd stays pending until its write has left the output stage.
    logic [NREG-1:0] slot_mask [DEPTH];
    logic [NREG-1:0] out_mask;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_mask
            assign slot_mask[gi] = valid_reg[gi] ? (NREG'(1) << fifo_rd_mem[gi]) : '0;
        end
    endgenerate

    assign out_mask = (rf_wr_en_reg && out_unit_reg) ? (NREG'(1) << rf_rd_reg) : '0;

    always_comb begin
        pending_mask = out_mask;
        for (int i = 0; i < DEPTH; i++)
            pending_mask = pending_mask | slot_mask[i];
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;
    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wr_en;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        pipe_stall;
    logic        rf_wr_en;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic [31:0] pending_mask;

    int checks = 0;
    int errors = 0;

    regfile_wr_arbiter #(
        .XLEN(32), .RF_ADDR_W(5), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .pipe_wr_en(pipe_wr_en), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data),
        .lu_ready(lu_ready), .pipe_stall(pipe_stall),
        .rf_wr_en(rf_wr_en), .rf_rd(rf_rd), .rf_data(rf_data),
        .pending_mask(pending_mask)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    // Unit results waiting in arrival order, how long the head has waited,
    // and what the regfile port should show after the current edge.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int          head_age;
    logic        m_wr;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_unit;
    logic        last_stall_held;

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (q[i]) m[q[i].rd] = 1'b1;
        if (m_wr && m_unit) m[m_rd] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        head_age = 0;
        m_wr = 1'b0; m_rd = '0; m_data = '0; m_unit = 1'b0;
        last_stall_held = 1'b0;
    endtask

    // Entered at posedge+1; drives one cycle, checks combinational and
    // registered outputs against the model, returns at the next posedge+1.
    task automatic cycle(input logic wr, input logic [4:0] prd, input logic [31:0] pd,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                         output logic got_stall, output logic got_ready);
        logic m_force, m_ready, pipe_g, pop_g;
        int   sz;
        ent_t h;
        pipe_wr_en = wr; pipe_rd = prd; pipe_data = pd;
        lu_valid = lv; lu_rd = lrd; lu_data = ld;
        #1;
        sz      = q.size();
        m_force = (sz > 0) && (head_age == STARVE_LIMIT);
        m_ready = (sz < DEPTH);
        got_stall = pipe_stall;
        got_ready = lu_ready;
        chk("pipe_stall", {63'd0, pipe_stall}, {63'd0, m_force});
        chk("lu_ready",   {63'd0, lu_ready},   {63'd0, m_ready});
        pipe_g = wr && (prd != 0) && !m_force;
        pop_g  = !pipe_g && (sz > 0);
        if (pipe_g)
            chk("pipe_rd_not_pending", {63'd0, pending_mask[prd]}, 64'd0);
        if (pipe_g) begin
            m_wr = 1'b1; m_rd = prd; m_data = pd; m_unit = 1'b0;
        end else if (pop_g) begin
            h = q.pop_front();
            m_wr = 1'b1; m_rd = h.rd; m_data = h.data; m_unit = 1'b1;
        end else begin
            m_wr = 1'b0; m_unit = 1'b0;
        end
        if (pop_g || sz == 0) head_age = 0;
        else if (head_age < STARVE_LIMIT) head_age++;
        if (lv && m_ready && lrd != 0) q.push_back('{lrd, ld});
        last_stall_held = m_force && wr;
        @(posedge clk); #1;
        chk("rf_wr_en",     {63'd0, rf_wr_en}, {63'd0, m_wr});
        chk("rf_rd",        {59'd0, rf_rd},    {59'd0, m_rd});
        chk("rf_data",      {32'd0, rf_data},  {32'd0, m_data});
        chk("pending_mask", {32'd0, pending_mask}, {32'd0, model_mask()});
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        pipe_wr_en = 0; pipe_rd = 0; pipe_data = 0; lu_valid = 0; lu_rd = 0; lu_data = 0;
        for (int i = 0; i < n; i++) begin
            #1;
            chk("reset_lu_ready", {63'd0, lu_ready}, 64'd0);
            @(posedge clk); #1;
            chk("reset_rf_wr_en", {63'd0, rf_wr_en}, 64'd0);
            chk("reset_rf_rd",    {59'd0, rf_rd}, 64'd0);
            chk("reset_rf_data",  {32'd0, rf_data}, 64'd0);
            chk("reset_mask",     {32'd0, pending_mask}, 64'd0);
        end
        rst = 1'b0;
        model_reset();
        $display("reset applied for %0d cycles", n);
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  prd;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        stall;
        logic        ready;
        logic        ewr;
        logic [4:0]  erd;
        logic [31:0] edata;
        logic [31:0] emask;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic s, r;
        logic        hwr;
        logic [4:0]  hprd;
        logic [31:0] hpd;

        // pipe only, x0 discard, idle-pipe unit push, full FIFO with forced drains
        tbl[0]  = '{1, 5,  32'hDEADBEEF, 0, 0, 0,     0, 1, 1, 5,  32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1, 0,  32'h55,       0, 0, 0,     0, 1, 0, 5,  32'hDEADBEEF, 32'h0};
        tbl[2]  = '{0, 0,  0,            1, 7, 32'h1234, 0, 1, 0, 5, 32'hDEADBEEF, 32'h80};
        tbl[3]  = '{0, 0,  0,            0, 0, 0,     0, 1, 1, 7,  32'h1234, 32'h80};
        tbl[4]  = '{0, 0,  0,            0, 0, 0,     0, 1, 0, 7,  32'h1234, 32'h0};
        tbl[5]  = '{1, 10, 32'hA0,       1, 3, 32'h33, 0, 1, 1, 10, 32'hA0,  32'h8};
        tbl[6]  = '{1, 11, 32'hA1,       1, 4, 32'h44, 0, 1, 1, 11, 32'hA1,  32'h18};
        tbl[7]  = '{1, 12, 32'hA2,       1, 5, 32'h55, 0, 0, 1, 12, 32'hA2,  32'h18};
        tbl[8]  = '{1, 13, 32'hA3,       0, 0, 0,     0, 0, 1, 13, 32'hA3,  32'h18};
        tbl[9]  = '{1, 14, 32'hA4,       0, 0, 0,     1, 0, 1, 3,  32'h33,  32'h18};
        tbl[10] = '{1, 14, 32'hA4,       0, 0, 0,     0, 1, 1, 14, 32'hA4,  32'h10};
        tbl[11] = '{1, 15, 32'hA5,       0, 0, 0,     0, 1, 1, 15, 32'hA5,  32'h10};
        tbl[12] = '{1, 16, 32'hA6,       0, 0, 0,     0, 1, 1, 16, 32'hA6,  32'h10};
        tbl[13] = '{1, 17, 32'hA7,       0, 0, 0,     1, 1, 1, 4,  32'h44,  32'h10};
        tbl[14] = '{1, 17, 32'hA7,       0, 0, 0,     0, 1, 1, 17, 32'hA7,  32'h0};

        model_reset();
        #1;
        do_reset(2);
        #1;
        chk("post_reset_lu_ready", {63'd0, lu_ready}, 64'd1);

        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].wr, tbl[i].prd, tbl[i].pd, tbl[i].lv, tbl[i].lrd, tbl[i].ld, s, r);
            chk("tbl_stall",  {63'd0, s}, {63'd0, tbl[i].stall});
            chk("tbl_ready",  {63'd0, r}, {63'd0, tbl[i].ready});
            chk("tbl_wr_en",  {63'd0, rf_wr_en}, {63'd0, tbl[i].ewr});
            chk("tbl_rd",     {59'd0, rf_rd}, {59'd0, tbl[i].erd});
            chk("tbl_data",   {32'd0, rf_data}, {32'd0, tbl[i].edata});
            chk("tbl_mask",   {32'd0, pending_mask}, {32'd0, tbl[i].emask});
            $display("vec %0d: stall=%0d ready=%0d -> wr=%0d rd=%0d data=%h mask=%h",
                     i, s, r, rf_wr_en, rf_rd, rf_data, pending_mask);
        end

        // simultaneous push/pop at count=1, then an x0 unit result
        cycle(0, 0, 0, 1, 8, 32'h88, s, r);
        cycle(0, 0, 0, 1, 9, 32'h99, s, r);
        chk("pushpop_rd",   {59'd0, rf_rd}, 64'd8);
        chk("pushpop_mask", {32'd0, pending_mask}, 64'h300);
        cycle(0, 0, 0, 1, 0, 32'hFF, s, r);
        chk("order_rd",   {59'd0, rf_rd}, 64'd9);
        chk("order_data", {32'd0, rf_data}, 64'h99);
        cycle(0, 0, 0, 0, 0, 0, s, r);
        chk("x0_dropped_wr", {63'd0, rf_wr_en}, 64'd0);
        chk("x0_dropped_mask", {32'd0, pending_mask}, 64'd0);
        $display("seq push/pop + x0 done: rd order 8,9; x0 result not written");

        // mid-operation reset with two entries buffered and head waiting two cycles
        cycle(1, 20, 32'hB0, 1, 1, 32'h11, s, r);
        cycle(1, 21, 32'hB1, 1, 2, 32'h22, s, r);
        cycle(1, 22, 32'hB2, 0, 0, 0, s, r);
        chk("pre_reset_mask", {32'd0, pending_mask}, 64'h6);
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 0, 0, s, r);
            chk("after_reset_no_write", {63'd0, rf_wr_en}, 64'd0);
            chk("after_reset_mask", {32'd0, pending_mask}, 64'd0);
        end
        $display("seq mid-op reset done: buffered results dropped");

        // randomized traffic against the model
        hwr = 0; hprd = 0; hpd = 0;
        for (int i = 0; i < 500; i++) begin
            logic        lv;
            logic [4:0]  lrd;
            logic [31:0] ld;
            if (!last_stall_held) begin
                hwr  = ($urandom_range(0, 9) < 7);
                hprd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
                hpd  = $urandom;
            end
            lv  = $urandom_range(0, 1) == 1;
            lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
            ld  = $urandom;
            cycle(hwr, hprd, hpd, lv, lrd, ld, s, r);
            if (rf_wr_en)
                $display("rand %0d: write rd=%0d data=%h %s", i, rf_rd, rf_data,
                         m_unit ? "unit" : "pipe");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
